mont_mult: RTL

Radix-2 bit-serial Montgomery multiplier for the RSA decryption datapath. Computes A·B·R⁻¹ mod N with R = 2^WIDTH. It sits directly downstream of the dbs_r divider, which supplies the R mod N and R² mod N constants used to enter and leave the Montgomery domain. The exponentiation controller drives it through a start/done handshake matching dbs_r.

---
 rtl/mont_mult_if.sv | 23 ++
 rtl/mont_mult.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/mont_mult_if.sv
// Start/done handshake and operand bus between the exponentiation controller
// and the Montgomery multiplier.
interface mont_mult_if #(
   parameter int WIDTH = 1024
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] n;
   logic [WIDTH-1:0] result;
   logic             busy;
   logic             done;

   modport master (
      output start, a, b, n,
      input  result, busy, done
   );

   modport slave (
      input  start, a, b, n,
      output result, busy, done
   );
endinterface

// File: rtl/mont_mult.sv
// Radix-2 bit-serial Montgomery multiplier: result = a*b*2^-WIDTH mod n.
// One bit of a per cycle, then a single conditional subtract.
module mont_mult #(
   parameter int WIDTH = 1024,
   parameter int CW    = 11
) (
   input  logic        clk,
   input  logic        reset,
   mont_mult_if.slave  bus
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ITER = 2'd1;
   localparam logic [1:0] ST_SUB  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   localparam logic [CW-1:0] LAST_I = CW'(WIDTH - 1);
   localparam logic [CW-1:0] ONE_I  = CW'(1);

   logic [1:0]       state_r;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic [WIDTH-1:0] n_r;
   logic [WIDTH+1:0] s_r;
   logic [CW-1:0]    i_r;
   logic [WIDTH-1:0] result_r;
   logic             busy_r;
   logic             done_r;

   logic [WIDTH+1:0] b_ext_s;
   logic [WIDTH+1:0] n_ext_s;
   logic [WIDTH+1:0] t_add_s;
   logic [WIDTH+1:0] t_s;
   logic [WIDTH+1:0] s_next_s;
   logic [WIDTH+1:0] diff_s;
   logic [WIDTH+1:0] fin_s;
   logic             ge_s;
   logic             last_s;
   logic             unused_bits_s;

   assign b_ext_s = {2'b00, b_r};
   assign n_ext_s = {2'b00, n_r};

   // Iteration datapath: add partial product, make even with n, halve.
   // With a,b < n the sum stays below 4n, so WIDTH+2 bits never overflow.
   always_comb begin
      t_add_s  = {(WIDTH+2){1'b0}};
      t_s      = {(WIDTH+2){1'b0}};
      s_next_s = {(WIDTH+2){1'b0}};
      if (a_r[0]) begin
         t_add_s = s_r + b_ext_s;
      end else begin
         t_add_s = s_r;
      end
      if (t_add_s[0]) begin
         t_s = t_add_s + n_ext_s;
      end else begin
         t_s = t_add_s;
      end
      s_next_s = {1'b0, t_s[WIDTH+1:1]};
   end

   // Final reduction: S < 2n after the loop, so one subtract is enough.
   always_comb begin
      diff_s = s_r - n_ext_s;
      ge_s   = (s_r >= n_ext_s);
      if (ge_s) begin
         fin_s = diff_s;
      end else begin
         fin_s = s_r;
      end
   end

   assign last_s = (i_r == LAST_I);

   // Discarded bits: the shifted-out LSB and the provably-zero top of fin_s.
   assign unused_bits_s = ^{t_s[0], fin_s[WIDTH+1:WIDTH]};

   // Control FSM and all registered state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r  <= ST_IDLE;
         a_r      <= {WIDTH{1'b0}};
         b_r      <= {WIDTH{1'b0}};
         n_r      <= {WIDTH{1'b0}};
         s_r      <= {(WIDTH+2){1'b0}};
         i_r      <= {CW{1'b0}};
         result_r <= {WIDTH{1'b0}};
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               done_r <= 1'b0;
               if (bus.start) begin
                  a_r     <= bus.a;
                  b_r     <= bus.b;
                  n_r     <= bus.n;
                  s_r     <= {(WIDTH+2){1'b0}};
                  i_r     <= {CW{1'b0}};
                  busy_r  <= 1'b1;
                  state_r <= ST_ITER;
               end else begin
                  busy_r  <= 1'b0;
                  state_r <= ST_IDLE;
               end
            end
            ST_ITER: begin
               s_r <= s_next_s;
               a_r <= {1'b0, a_r[WIDTH-1:1]};
               i_r <= i_r + ONE_I;
               if (last_s) begin
                  state_r <= ST_SUB;
               end else begin
                  state_r <= ST_ITER;
               end
            end
            ST_SUB: begin
               result_r <= fin_s[WIDTH-1:0];
               busy_r   <= 1'b0;
               done_r   <= 1'b1;
               state_r  <= ST_DONE;
            end
            ST_DONE: begin
               done_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
            default: begin
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.result = result_r;
   assign bus.busy   = busy_r;
   assign bus.done   = done_r;

endmodule
